// File: rtl/filter_sample_tx_pkg.sv
// rtl/filter_sample_tx_pkg.sv - shared types and constants for the filter sample transmitter
package filter_sample_tx_pkg;

   localparam int FILT_W = 4;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_WAIT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/filter_sample_tx_sync_fifo.sv
// rtl/filter_sample_tx_sync_fifo.sv - synchronous FIFO with wrapping pointers and occupancy level
module filter_sample_tx_sync_fifo
   import filter_sample_tx_pkg::*;
#(
   parameter int W     = FILT_W,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_count;
   logic          w_wr_en;
   logic          w_rd_en;

   assign w_wr_en = i_push && !o_full;
   assign w_rd_en = i_pop && !o_empty;

   // Storage carries no reset; only the pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full  = (r_count == LW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_count;

endmodule

// File: rtl/filter_sample_tx.sv
// rtl/filter_sample_tx.sv - paced one-cycle strobe transmitter of queued samples into the filters
module filter_sample_tx
   import filter_sample_tx_pkg::*;
#(
   parameter int W     = FILT_W,
   parameter int DEPTH = 4,
   parameter int GAP   = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   input  logic [W-1:0]             i_in_data,
   input  logic                     i_pause,
   output logic [W-1:0]             o_x,
   output logic                     o_x_is_valid,
   output logic                     o_busy,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

   tx_state_t     r_state;
   tx_state_t     w_next_state;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_x;
   logic          r_x_is_valid;

   logic          w_full;
   logic          w_empty;
   logic [W-1:0]  w_head;
   logic          w_push;
   logic          w_pop;
   logic          w_can_pop;
   logic          w_gap_done;

   assign w_push     = i_in_valid && !w_full;
   assign w_can_pop  = !w_empty && !i_pause;
   assign w_gap_done = (r_cnt == '0);

   filter_sample_tx_sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (i_in_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_level)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= TX_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // The last WAIT cycle may pop directly so throughput stays at one per GAP+1 cycles.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         TX_IDLE: begin
            if (w_can_pop) begin
               w_next_state = TX_SEND;
            end
         end
         TX_SEND: begin
            if (GAP == 0) begin
               w_next_state = w_can_pop ? TX_SEND : TX_IDLE;
            end else begin
               w_next_state = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (w_gap_done) begin
               w_next_state = w_can_pop ? TX_SEND : TX_IDLE;
            end
         end
         default: w_next_state = TX_IDLE;
      endcase
   end

   always_comb begin
      w_pop = 1'b0;
      case (r_state)
         TX_IDLE: w_pop = w_can_pop;
         TX_SEND: w_pop = (GAP == 0) && w_can_pop;
         TX_WAIT: w_pop = w_gap_done && w_can_pop;
         default: w_pop = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (r_state == TX_SEND) begin
         r_cnt <= GAP_LOAD;
      end else if (r_state == TX_WAIT && !w_gap_done) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_x          <= '0;
         r_x_is_valid <= 1'b0;
      end else begin
         r_x_is_valid <= w_pop;
         if (w_pop) begin
            r_x <= w_head;
         end
      end
   end

   assign o_x          = r_x;
   assign o_x_is_valid = r_x_is_valid;
   assign o_in_ready   = !w_full;
   assign o_busy       = !w_empty || (r_state != TX_IDLE);

endmodule

// File: tb/tb_filter_sample_tx.sv
// tb/tb_filter_sample_tx.sv - scoreboard bench for filter_sample_tx with GAP=0 and GAP=2 instances
module tb_filter_sample_tx;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       pause;

   logic       rdy0, v0, busy0;
   logic [3:0] x0;
   logic [2:0] lvl0;
   logic       rdy2, v2, busy2;
   logic [3:0] x2;
   logic [2:0] lvl2;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   logic [3:0] q0[$];
   logic [3:0] q2[$];
   int         stamps2[$];
   int         n_strobe0 = 0;
   int         n_strobe2 = 0;
   int         run0 = 0;
   int         last_run0 = 0;
   int         acc2 = 0;

   filter_sample_tx #(.W(4), .DEPTH(4), .GAP(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy0),
      .i_in_data(in_data), .i_pause(pause), .o_x(x0), .o_x_is_valid(v0),
      .o_busy(busy0), .o_level(lvl0)
   );

   filter_sample_tx #(.W(4), .DEPTH(4), .GAP(2)) u_dut2 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy2),
      .i_in_data(in_data), .i_pause(pause), .o_x(x2), .o_x_is_valid(v2),
      .o_busy(busy2), .o_level(lvl2)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] e;
      if (v0) begin
         n_strobe0++;
         run0++;
         check("sb0_avail", 32'(q0.size() == 0), 0);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("sb0_data", 32'(x0), 32'(e));
         end
      end else begin
         if (run0 != 0) last_run0 = run0;
         run0 = 0;
      end
      if (v2) begin
         n_strobe2++;
         stamps2.push_back(cyc);
         check("sb2_avail", 32'(q2.size() == 0), 0);
         if (q2.size() != 0) begin
            e = q2.pop_front();
            check("sb2_data", 32'(x2), 32'(e));
         end
      end
   end

   task automatic push(input logic [3:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      if (rdy0) q0.push_back(d);
      if (rdy2) begin
         q2.push_back(d);
         acc2++;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy0 && !busy2) break;
      end
      check("idle_timeout", 32'(busy0 || busy2), 0);
      @(negedge clk);
   endtask

   initial begin
      int base2, n0b, n2b, a2b;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; pause = 1'b0;

      // 1: reset and single sample
      repeat (2) @(negedge clk);
      check("rst_x0", 32'(x0), 0);
      check("rst_v0", 32'(v0), 0);
      check("rst_rdy0", 32'(rdy0), 1);
      check("rst_lvl0", 32'(lvl0), 0);
      check("rst_busy0", 32'(busy0), 0);
      check("rst_v2", 32'(v2), 0);
      check("rst_rdy2", 32'(rdy2), 1);
      rst = 1'b1;
      push(4'b0101);
      @(negedge clk);
      in_valid = 1'b0;
      check("t1_lat_v0", 32'(v0), 0);
      check("t1_lat_lvl0", 32'(lvl0), 1);
      @(negedge clk);
      check("t1_v0", 32'(v0), 1);
      check("t1_x0", 32'(x0), 32'h5);
      check("t1_v2", 32'(v2), 1);
      check("t1_x2", 32'(x2), 32'h5);
      @(negedge clk);
      check("t1_v0_off", 32'(v0), 0);
      check("t1_x0_hold", 32'(x0), 32'h5);
      check("t1_v2_off", 32'(v2), 0);
      wait_idle();

      // 2: burst, GAP=0 runs four strobes back-to-back
      push(4'b0111); push(4'b0100); push(4'b1000); push(4'b1111);
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      check("t2_run0", 32'(last_run0), 4);
      check("t2_lvl0", 32'(lvl0), 0);
      check("t2_lvl2", 32'(lvl2), 0);

      // 3: fill to DEPTH, then drain with GAP=2 spacing
      pause = 1'b1;
      for (int i = 1; i <= 6; i++) push(4'(i));
      @(negedge clk);
      in_valid = 1'b0;
      check("t3_lvl0", 32'(lvl0), 4);
      check("t3_lvl2", 32'(lvl2), 4);
      check("t3_rdy0", 32'(rdy0), 0);
      check("t3_rdy2", 32'(rdy2), 0);
      check("t3_q2", 32'(q2.size()), 4);
      base2 = stamps2.size();
      n0b = n_strobe0;
      pause = 1'b0;
      wait_idle();
      check("t3_n0", 32'(n_strobe0 - n0b), 4);
      check("t3_n2", 32'(stamps2.size() - base2), 4);
      for (int i = base2 + 1; i < stamps2.size(); i++)
         check("t3_space2", 32'(stamps2[i] - stamps2[i-1]), 3);

      // 4: pause withholds transmission
      pause = 1'b1;
      push(4'b0101); push(4'b0111);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t4_v0", 32'(v0), 0);
         check("t4_v2", 32'(v2), 0);
         check("t4_x0", 32'(x0), 32'h4);
         check("t4_busy0", 32'(busy0), 1);
         check("t4_busy2", 32'(busy2), 1);
         @(negedge clk);
      end
      pause = 1'b0;
      @(negedge clk);
      check("t4_rel_v0", 32'(v0), 1);
      check("t4_rel_x0", 32'(x0), 32'h5);
      check("t4_rel_v2", 32'(v2), 1);
      check("t4_rel_x2", 32'(x2), 32'h5);
      wait_idle();

      // 5: asynchronous reset mid-burst
      pause = 1'b1;
      push(4'hA); push(4'hB); push(4'hC);
      @(negedge clk);
      in_valid = 1'b0;
      check("t5_lvl0", 32'(lvl0), 3);
      check("t5_lvl2", 32'(lvl2), 3);
      pause = 1'b0;
      @(posedge clk);
      #5;
      check("t5_pre_v0", 32'(v0), 1);
      check("t5_pre_v2", 32'(v2), 1);
      rst = 1'b0;
      #1;
      check("t5_v0", 32'(v0), 0);
      check("t5_lvl0", 32'(lvl0), 0);
      check("t5_v2", 32'(v2), 0);
      check("t5_lvl2", 32'(lvl2), 0);
      check("t5_busy0", 32'(busy0), 0);
      q0.delete();
      q2.delete();
      n0b = n_strobe0;
      n2b = n_strobe2;
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("t5_quiet0", 32'(n_strobe0 - n0b), 0);
      check("t5_quiet2", 32'(n_strobe2 - n2b), 0);
      check("t5_x0", 32'(x0), 0);

      // 6: wrap-around across 2*DEPTH+1 samples
      n0b = n_strobe0;
      n2b = n_strobe2;
      a2b = acc2;
      for (int i = 0; i < 9; i++) push(4'(i));
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle();
      check("t6_n0", 32'(n_strobe0 - n0b), 9);
      check("t6_n2", 32'(n_strobe2 - n2b), 32'(acc2 - a2b));
      check("t6_q0", 32'(q0.size()), 0);
      check("t6_q2", 32'(q2.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
